calc_accumulator: RTL and testbench
===================================

Name: calc_accumulator

Overview:
- Sequential front-end for the team's signed combinational calculator (CombCalc).
- Accepts a stream of opcode/operand commands over a valid/ready handshake.
- Feeds a registered accumulator as operand A and the command operand as B.
- Returns each result, with its overflow flag, through a one-entry valid/ready result register. Also keeps a sticky overflow flag and a saturating operation counter.
- Drives the command side of the calculator interface in hardware; it is the counterpart to the stimulus the combinational calculator has only received from benches so far.

Parameters:
- W, 16, operand/result/accumulator width (two's complement).
- CW, 8, width of op_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_op  in  3  calculator opcode
- cmd_clr  in  1  load cmd_data into accumulator; no arithmetic
- cmd_data  in  W  signed operand B
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  downstream consumes result
- res_data  out  W  signed result
- res_ovf  out  1  overflow flag of res_data
- sticky_ovf  out  1  OR of all ovf since last clr/reset
- acc  out  W  current accumulator value
- op_count  out  CW  accepted arithmetic commands since last clr/reset, saturating

Behaviour:
- Reset (async, rst_n=0):
  - acc=0, res_data=0, res_ovf=0, res_valid=0, sticky_ovf=0, op_count=0.
  - FSM enters EMPTY. Reset mid-transaction discards any held result.
- Opcodes, with A=acc and B=cmd_data:
  - 000 A+B; 001 A-B; 010/011 |B|; 100 B+A; 101 B-A; 110/111 |A|.
  - All arithmetic is W bits, wrap-around.
  - ovf on add: operands have the same sign and the result sign differs.
  - ovf on sub: operands have different signs and the result sign differs from the minuend.
  - ovf on abs: operand is -2^(W-1); result is -2^(W-1), ovf=1.
- cmd_ready = !res_valid || res_ready (combinational). Accept = cmd_valid && cmd_ready.
- FSM:
  - EMPTY (res_valid=0): accept -> FULL.
  - FULL (res_valid=1):
    - res_ready && !cmd_valid -> EMPTY.
    - res_ready && cmd_valid -> stay FULL with the new result (back-to-back, one result per cycle).
    - !res_ready -> hold; res_data and res_ovf stable; cmd_ready=0.
- On accept with cmd_clr=0 (1-cycle latency; all updates registered on the next edge):
  - acc <= R; res_data <= R; res_ovf <= ovf.
  - sticky_ovf <= sticky_ovf | ovf.
  - op_count <= op_count+1, saturating at 2^CW-1.
- On accept with cmd_clr=1:
  - acc <= cmd_data; res_data <= cmd_data; res_ovf <= 0.
  - sticky_ovf <= 0; op_count <= 0; cmd_op ignored.
- cmd_valid while cmd_ready=0: no state change. The sender holds the command; the block does not sample it.
- acc updates only on accept. Overflow never blocks the update: the wrapped value is stored.

Decomposition:
- Shared package calc_pkg holds:
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_ABSB=01x, OP_RADD=100, OP_RSUB=101, OP_ABSA=11x;
  - state enum {EMPTY, FULL}.
- Sub-module: instantiate the existing CombCalc (#W) for R/ovf. No new datapath module.

Test Plan:
- Reset, then clr with data=10, then op 000 data=5 -> res_data=10 (ovf 0), then res_data=15, acc=15, op_count=1.
- acc=-15 (via clr), op 101 data=30 -> res_data=45; then op 001 data=-25 -> 70; sticky_ovf=0.
- acc=32760, op 000 data=100 -> res_data=-32676, res_ovf=1, sticky_ovf=1. Next op 000 data=1 -> res_ovf=0, sticky_ovf still 1.
- acc=-32768, op 110 -> res_data=-32768, res_ovf=1. Op 010 data=-100 -> res_data=100, res_ovf=0.
- Backpressure: res_ready=0 with cmd_valid=1 for 3 cycles -> cmd_ready=0, acc and res_data frozen. Then res_ready=1 -> one accept per cycle, results in order.
- Assert rst_n low while FULL -> res_valid, acc, sticky_ovf, op_count all 0 immediately. Also: 260 arithmetic ops with CW=8 -> op_count=255.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants and result-register state type for the calculator slice.
package calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;  // A + B
  localparam logic [2:0] OP_SUB  = 3'b001;  // A - B
  localparam logic [2:0] OP_ABSB = 3'b010;  // |B| (bit 0 is don't-care)
  localparam logic [2:0] OP_RADD = 3'b100;  // B + A
  localparam logic [2:0] OP_RSUB = 3'b101;  // B - A
  localparam logic [2:0] OP_ABSA = 3'b110;  // |A| (bit 0 is don't-care)

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/calc_accumulator_if.sv
// Command/result handshake bundle between a command source and calc_accumulator.
interface calc_accumulator_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         cmd_clr;
  logic [W-1:0] cmd_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_clr, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_clr, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/calc_accumulator_combcalc.sv
// CombCalc: signed W-bit combinational calculator (add/sub/reverse/abs) with overflow.
module CombCalc
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] r,
  output logic         ovf
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sub;
  logic         absop;

  // Operand steering, then one shared add/sub/abs evaluation with overflow detect.
  always_comb begin
    x     = a;
    y     = b;
    sub   = 1'b0;
    absop = 1'b0;
    r     = '0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD:  begin x = a; y = b; end
      OP_SUB:  begin x = a; y = b; sub = 1'b1; end
      OP_RADD: begin x = b; y = a; end
      OP_RSUB: begin x = b; y = a; sub = 1'b1; end
      default: begin absop = 1'b1; x = op[2] ? a : b; end
    endcase
    if (absop) begin
      r   = x[W-1] ? ('0 - x) : x;
      ovf = x[W-1] && (x[W-2:0] == '0);
    end else if (sub) begin
      r   = x - y;
      ovf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r   = x + y;
      ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
  end

endmodule

// File: rtl/calc_accumulator.sv
// calc_accumulator: handshake front-end that accumulates CombCalc results.
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_accumulator_if.slave    bus,
  output logic                 sticky_ovf,
  output logic [W-1:0]         acc,
  output logic [CW-1:0]        op_count
);

  state_t       state;
  logic [W-1:0] res_data_q;
  logic         res_ovf_q;
  logic [W-1:0] calc_r;
  logic         calc_ovf;
  logic         res_valid;
  logic         accept;

  CombCalc #(.W(W)) u_calc (
    .a   (acc),
    .b   (bus.cmd_data),
    .op  (bus.cmd_op),
    .r   (calc_r),
    .ovf (calc_ovf)
  );

  assign res_valid     = (state == FULL);
  assign bus.cmd_ready = !res_valid || bus.res_ready;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

  // Result-register occupancy plus accumulator/status update on each accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      acc        <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else if (accept) begin
      state <= FULL;
      if (bus.cmd_clr) begin
        acc        <= bus.cmd_data;
        res_data_q <= bus.cmd_data;
        res_ovf_q  <= 1'b0;
        sticky_ovf <= 1'b0;
        op_count   <= '0;
      end else begin
        acc        <= calc_r;
        res_data_q <= calc_r;
        res_ovf_q  <= calc_ovf;
        sticky_ovf <= sticky_ovf | calc_ovf;
        if (op_count != '1)
          op_count <= op_count + CW'(1);
      end
    end else if (bus.res_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_calc_accumulator.sv
// Self-checking bench for calc_accumulator: directed table, corner sequences, random vs model.
module tb_calc_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sticky_ovf;
  logic [15:0] acc;
  logic [7:0]  op_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_acc, m_res, m_cnt;
  bit m_ovf, m_valid, m_sticky;

  calc_accumulator_if #(.W(16)) bus ();

  calc_accumulator #(.W(16), .CW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sticky_ovf (sticky_ovf),
    .acc        (acc),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact-integer reference: compute the mathematical result, flag out-of-range, then wrap.
  function automatic void ref_calc(input int op, input int a, input int b, output int r, output bit ovf);
    int full;
    case (op)
      0:       full = a + b;
      1:       full = a - b;
      2, 3:    full = (b < 0) ? -b : b;
      4:       full = b + a;
      5:       full = b - a;
      default: full = (a < 0) ? -a : a;
    endcase
    ovf = (full > 32767) || (full < -32768);
    r = full;
    if (r > 32767) r -= 65536;
    else if (r < -32768) r += 65536;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_res = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; m_sticky = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'(m_valid));
    chk({tag, "_res_data"}, 32'($signed(bus.res_data)), m_res);
    chk({tag, "_res_ovf"}, 32'(bus.res_ovf), 32'(m_ovf));
    chk({tag, "_acc"}, 32'($signed(acc)), m_acc);
    chk({tag, "_sticky"}, 32'(sticky_ovf), 32'(m_sticky));
    chk({tag, "_op_count"}, 32'(op_count), m_cnt);
  endtask

  // One clock: drive inputs, check cmd_ready, advance the model at the edge, check outputs.
  task automatic cycle(input bit v, input int op, input bit clr, input int data, input bit rr);
    bit acc_ok;
    int r;
    bit o;
    bus.cmd_valid = v;
    bus.cmd_op    = op[2:0];
    bus.cmd_clr   = clr;
    bus.cmd_data  = data[15:0];
    bus.res_ready = rr;
    #1;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_valid || rr));
    acc_ok = v && (!m_valid || rr);
    @(posedge clk);
    if (acc_ok) begin
      if (clr) begin
        m_acc = data; m_res = data; m_ovf = 0; m_sticky = 0; m_cnt = 0;
      end else begin
        ref_calc(op, m_acc, data, r, o);
        m_acc = r; m_res = r; m_ovf = o; m_sticky = m_sticky | o;
        if (m_cnt < 255) m_cnt++;
      end
      m_valid = 1;
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
    check_state("cyc");
  endtask

  typedef struct {
    int op; bit clr; int data;
    int exp_res; bit exp_ovf; bit exp_sticky; int exp_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [15:0] d16;
    int dv;

    tbl[0]  = '{0, 1, 10,     10,     0, 0, 0};
    tbl[1]  = '{0, 0, 5,      15,     0, 0, 1};
    tbl[2]  = '{0, 1, -15,    -15,    0, 0, 0};
    tbl[3]  = '{5, 0, 30,     45,     0, 0, 1};
    tbl[4]  = '{1, 0, -25,    70,     0, 0, 2};
    tbl[5]  = '{0, 1, 32760,  32760,  0, 0, 0};
    tbl[6]  = '{0, 0, 100,    -32676, 1, 1, 1};
    tbl[7]  = '{0, 0, 1,      -32675, 0, 1, 2};
    tbl[8]  = '{0, 1, -32768, -32768, 0, 0, 0};
    tbl[9]  = '{6, 0, 0,      -32768, 1, 1, 1};
    tbl[10] = '{2, 0, -100,   100,    0, 1, 2};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_clr = 1'b0;
    bus.cmd_data = '0; bus.res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res_valid", 32'(bus.res_valid), 0);
    chk("reset_acc", 32'(acc), 0);
    chk("reset_res_data", 32'(bus.res_data), 0);
    chk("reset_op_count", 32'(op_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, always-ready downstream
    for (int i = 0; i < 11; i++) begin
      cycle(1, tbl[i].op, tbl[i].clr, tbl[i].data, 1);
      chk("tbl_res", 32'($signed(bus.res_data)), tbl[i].exp_res);
      chk("tbl_acc", 32'($signed(acc)), tbl[i].exp_res);
      chk("tbl_ovf", 32'(bus.res_ovf), 32'(tbl[i].exp_ovf));
      chk("tbl_sticky", 32'(sticky_ovf), 32'(tbl[i].exp_sticky));
      chk("tbl_cnt", 32'(op_count), tbl[i].exp_cnt);
    end

    // Backpressure: FULL with res_ready low freezes everything
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 7, 0);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("bp_acc", 32'($signed(acc)), 100);
      chk("bp_res", 32'($signed(bus.res_data)), 100);
    end
    cycle(1, 0, 0, 7, 1);
    chk("b2b_res0", 32'($signed(bus.res_data)), 107);
    cycle(1, 0, 0, 8, 1);
    chk("b2b_res1", 32'($signed(bus.res_data)), 115);
    cycle(1, 0, 0, 9, 1);
    chk("b2b_res2", 32'($signed(bus.res_data)), 124);
    cycle(0, 0, 0, 0, 1);
    chk("drain_valid", 32'(bus.res_valid), 0);

    // Asynchronous reset while FULL
    cycle(1, 0, 0, 3, 0);
    chk("pre_rst_valid", 32'(bus.res_valid), 1);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(bus.res_valid), 0);
    chk("arst_acc", 32'(acc), 0);
    chk("arst_sticky", 32'(sticky_ovf), 0);
    chk("arst_cnt", 32'(op_count), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Saturating op counter
    cycle(1, 0, 1, 0, 1);
    for (int i = 0; i < 260; i++) cycle(1, 0, 0, 1, 1);
    chk("sat_cnt", 32'(op_count), 255);
    chk("sat_acc", 32'($signed(acc)), 260);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: dv = -32768;
        1: dv = 32767;
        default: begin d16 = 16'($urandom); dv = int'($signed(d16)); end
      endcase
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 15) == 0, dv, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
